// File: rtl/z80_bus_responder.sv
// z80_bus_responder
//   Synchronous memory/IO responder for the tv80s CPU bus. Decodes refresh,
//   interrupt-acknowledge, IO and memory cycles, inserts a programmable number
//   of wait states, serves reads from registered `di`, commits writes once per
//   bus cycle and logs each committed write into a trace FIFO.
//
// Ports
//   clk, reset_n                      clock, asynchronous active-low reset
//   m1_n, mreq_n, iorq_n, rd_n,
//   wr_n, rfsh_n                      CPU bus strobes
//   A[15:0], dout[7:0]                CPU address and write data
//   di[7:0], wait_n                   registered read data and wait request
//   ld_we, ld_addr, ld_data           backdoor memory preload port
//   trace_valid/ready/data            write-trace FIFO head {is_io, A, data}
//   trace_count                       entries held in the trace FIFO
//   trace_ovf                         sticky: a write was dropped on a full FIFO
module z80_bus_responder #(
    parameter int         MAW      = 16,
    parameter int         IOAW     = 8,
    parameter int         WAIT_MEM = 0,
    parameter int         WAIT_IO  = 1,
    parameter logic [7:0] INT_VEC  = 8'hFF,
    parameter int         TDEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      m1_n,
    input  logic                      mreq_n,
    input  logic                      iorq_n,
    input  logic                      rd_n,
    input  logic                      wr_n,
    input  logic                      rfsh_n,
    input  logic [15:0]               A,
    input  logic [7:0]                dout,
    output logic [7:0]                di,
    output logic                      wait_n,
    input  logic                      ld_we,
    input  logic [MAW-1:0]            ld_addr,
    input  logic [7:0]                ld_data,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [24:0]               trace_data,
    output logic [$clog2(TDEPTH):0]   trace_count,
    output logic                      trace_ovf
);

    localparam int TAW = $clog2(TDEPTH);
    localparam int CW  = TAW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_HOLD} state_t;

    state_t      state, next_state;
    logic [3:0]  cnt;
    logic [3:0]  load_val;
    logic        kind_io, kind_inta;

    logic        is_rfsh, is_inta, is_io, is_mem;
    logic        bus_cyc, bus_rw, strobes_off;
    logic        acc_inta, acc_rd, acc_wr;

    logic [7:0]  mem    [0:(1<<MAW)-1];
    logic [7:0]  io_arr [0:(1<<IOAW)-1];
    logic [24:0] fifo   [0:TDEPTH-1];

    logic [TAW-1:0] wr_ptr, rd_ptr;
    logic           push, pop, full, push_ok;

    logic [MAW-1:0]  mem_idx;
    logic [IOAW-1:0] io_idx;

    assign mem_idx = A[MAW-1:0];
    assign io_idx  = A[IOAW-1:0];

    // Cycle decode, priority order: refresh, INTA, IO, MEM.
    always_comb begin
        is_rfsh = !mreq_n && !rfsh_n;
        is_inta = !is_rfsh && !m1_n && !iorq_n;
        is_io   = !is_rfsh && !is_inta && !iorq_n && m1_n;
        is_mem  = !is_rfsh && !is_inta && !is_io && !mreq_n && rfsh_n;
    end

    assign bus_cyc     = is_inta || is_io || is_mem;
    assign bus_rw      = !rd_n || !wr_n;
    assign strobes_off = mreq_n && iorq_n && rd_n && wr_n;

    always_comb begin
        if (is_inta)
            load_val = 4'd0;
        else if (is_io)
            load_val = 4'(WAIT_IO);
        else
            load_val = 4'(WAIT_MEM);
    end

    // State register plus the registered datapath/handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            kind_io   <= 1'b0;
            kind_inta <= 1'b0;
            di        <= 8'h00;
            wait_n    <= 1'b1;
        end else begin
            state  <= next_state;
            // wait_n follows the state being entered, so it drops on the
            // IDLE->WAIT edge and rises on the WAIT->ACCESS (or abort) edge.
            wait_n <= (next_state != S_WAIT);
            if (state == S_IDLE && bus_cyc) begin
                cnt       <= load_val;
                kind_io   <= is_io;
                kind_inta <= is_inta;
            end else if (state == S_WAIT && cnt != 4'd1) begin
                cnt <= cnt - 4'd1;
            end
            if (acc_inta)
                di <= INT_VEC;
            else if (acc_rd)
                di <= kind_io ? io_arr[io_idx] : mem[mem_idx];
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (bus_cyc)
                    next_state = (load_val != 4'd0) ? S_WAIT : S_ACCESS;
            end
            S_WAIT: begin
                if (strobes_off)
                    next_state = S_IDLE;
                else if (cnt == 4'd1)
                    next_state = S_ACCESS;
            end
            S_ACCESS: begin
                // INTA has no rd/wr strobe; memory may assert MREQ before RD/WR.
                if (kind_inta || bus_rw)
                    next_state = S_HOLD;
                else if (strobes_off)
                    next_state = S_IDLE;
            end
            S_HOLD: begin
                if (strobes_off)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Commit strobes: only ever asserted for the single ACCESS clock.
    always_comb begin
        acc_inta = 1'b0;
        acc_rd   = 1'b0;
        acc_wr   = 1'b0;
        if (state == S_ACCESS) begin
            if (kind_inta)
                acc_inta = 1'b1;
            else if (!rd_n)
                acc_rd = 1'b1;
            else if (!wr_n)
                acc_wr = 1'b1;
        end
    end

    // Bus write is placed after the backdoor write so it wins on a collision.
    always_ff @(posedge clk) begin
        if (ld_we)
            mem[ld_addr] <= ld_data;
        if (acc_wr && !kind_io)
            mem[mem_idx] <= dout;
    end

    always_ff @(posedge clk) begin
        if (acc_wr && kind_io)
            io_arr[io_idx] <= dout;
    end

    // Trace FIFO. A push on a full FIFO is accepted only when a pop frees the
    // head slot on the same edge.
    assign push    = acc_wr;
    assign pop     = trace_valid && trace_ready;
    assign full    = (trace_count == CW'(TDEPTH));
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (push_ok)
            fifo[wr_ptr] <= {kind_io, A, dout};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            trace_count <= '0;
            trace_ovf   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   trace_count <= trace_count + 1'b1;
                2'b01:   trace_count <= trace_count - 1'b1;
                default: trace_count <= trace_count;
            endcase
            if (push && !push_ok)
                trace_ovf <= 1'b1;
        end
    end

    assign trace_valid = (trace_count != '0);
    assign trace_data  = trace_valid ? fifo[rd_ptr] : 25'd0;

endmodule

// File: doc/z80_bus_responder.md
# z80_bus_responder

Synthesizable, parametrised memory/IO bus responder for the `tv80s` CPU bus, replacing the behavioural negedge memory arrays in instruction testbenches. It serves memory and IO reads and commits writes. It inserts a programmable number of wait states per cycle type and answers interrupt-acknowledge cycles with a fixed vector. Every committed write is logged into a trace FIFO so benches can check write order, not just final memory contents.

## Interface
- `MAW`, 16: memory address bits decoded; depth is 2^MAW bytes; `A[15:MAW]` ignored (aliasing).
- `IOAW`, 8: IO address bits decoded from `A[IOAW-1:0]`.
- `WAIT_MEM`, 0: wait states inserted per memory read/write cycle (0–15).
- `WAIT_IO`, 1: wait states inserted per IO read/write cycle (0–15).
- `INT_VEC`, 8'hFF: byte returned on interrupt-acknowledge (`m1_n=0 & iorq_n=0`).
- `TDEPTH`, 16: trace FIFO entries (power of two, ≥2).
- `clk` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n` in 1 each: CPU bus strobes.
- `A` in 16: CPU address.
- `dout` in 8: CPU write data.
- `di` out 8: read data to CPU (registered).
- `wait_n` out 1: wait request to CPU (registered).
- `ld_we` in 1, `ld_addr` in MAW, `ld_data` in 8: backdoor memory preload.
- `trace_valid` out 1, `trace_ready` in 1, `trace_data` out 25: FIFO head `{is_io, A[15:0], data}`.
- `trace_count` out $clog2(TDEPTH)+1: entries held.
- `trace_ovf` out 1: sticky, set when a write is dropped on a full FIFO.

## Operation
- Cycle decode, first match wins:
  - refresh: `mreq_n=0 & rfsh_n=0`, ignored.
  - INTA: `m1_n=0 & iorq_n=0`.
  - IO: `iorq_n=0 & m1_n=1`.
  - MEM: `mreq_n=0 & rfsh_n=1`.
  - A cycle is a read or a write as soon as `rd_n=0` or `wr_n=0`.
- FSM states: IDLE, WAIT, ACCESS, HOLD.
- IDLE: on a decoded cycle, load the counter with WAIT_MEM, WAIT_IO, or 0 for INTA. Go to WAIT if the count is nonzero, else ACCESS.
- WAIT: `wait_n=0`. Decrement each clock. When the counter reaches 1, go to ACCESS; `wait_n` returns to 1 on that same edge.
- ACCESS, one clock:
  - Read: `di <= mem[A[MAW-1:0]]` or `io[A[IOAW-1:0]]`.
  - INTA: `di <= INT_VEC`.
  - Write: store `dout` and push `{is_io, A, dout}` to the trace FIFO.
  - If neither `rd_n` nor `wr_n` is low yet (early MREQ), stay in ACCESS until one is.
  - Then go to HOLD.
- HOLD: `di` holds its value. Return to IDLE when all of `mreq_n`, `iorq_n`, `rd_n`, `wr_n` are high. Exactly one commit per bus cycle, however long the strobes stay low.
- Strobes released during WAIT (abort): return to IDLE, no commit, `wait_n` back to 1 next edge.
- Backdoor: `ld_we=1` writes `mem[ld_addr]` on the edge, in any state. If a bus write to the same address commits on the same edge, the bus write wins. Not traced.
- Trace FIFO:
  - Push when full: entry dropped, `trace_ovf<=1`.
  - Pop on `trace_valid & trace_ready`.
  - Push and pop on the same edge: always allowed, including when full; count unchanged.
  - Pointers wrap modulo TDEPTH.
- IO space is a separate array of 2^IOAW bytes. Memory and IO arrays are not cleared by reset.

## Timing
- Reset values: `di=8'h00`, `wait_n=1`, `trace_valid=0`, `trace_data=0`, `trace_count=0`, `trace_ovf=0`, FSM IDLE.
- `reset_n` low mid-cycle: immediate return to IDLE. Any pending write is lost; FIFO is emptied.
- Read latency with zero waits: strobe sampled at edge N (IDLE→ACCESS), `di` valid after edge N+1.
- Read latency with W waits: `wait_n` low after edge N, high after edge N+W. `di` valid after edge N+W+1.
- Write commits on the ACCESS edge. `trace_valid` rises after the same edge if the FIFO was empty.
- `trace_count` updates on the push/pop edge; `trace_valid = (trace_count != 0)`.

## Test plan
- Backdoor-load `0000:DD CB 5E 6C`, `3E7F:2A`; reset with IX=3E21; run `DD CB 5E 6C` → after 20 clocks PC=0004, F=39, no trace entries, `trace_ovf=0`.
- MAW=16, WAIT_MEM=2: CPU executes `LD (8000h),A` with A=5A → `wait_n` low for exactly 2 clocks per memory cycle; `mem[8000]=5A`; one trace entry `{0,8000,5A}`.
- WAIT_IO=3: `OUT (7Fh),A` with A=C3 → `io[7F]=C3`, trace `{1,xx7F,C3}`; then `IN A,(7Fh)` → A=C3, `wait_n` low 3 clocks on each IO cycle.
- TDEPTH=4, `trace_ready=0`, 5 writes → `trace_count=4`, `trace_ovf=1`, first four entries in order. Simultaneous pop+push on full → count stays 4, `trace_ovf` unchanged.
- MAW=12: write to 1234h → readback from 0234h returns the same byte (aliasing). Backdoor write and bus write to 0234 on the same edge → bus data stored.
- Assert `reset_n` during WAIT of a write → `wait_n=1` and FIFO empty immediately; memory unchanged.
